exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_unit_pkg.sv | 34 +++
 rtl/exec_unit_mul.sv | 63 ++++++
 rtl/exec_unit.sv | 184 ++++++++++++++++++
 tb/tb_exec_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_unit_pkg.sv
// Shared vr16 definitions: datapath width, opcode encodings, FSM state encoding.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package exec_unit_pkg;

  localparam int VR16_WIDTH = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC     = 3'd1,
    S_MUL      = 3'd2,
    S_WRITE    = 3'd3,
    S_WAIT_ACK = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  // Opcodes 11..15 are reserved and flag an error.
  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_CMP;
  endfunction

endpackage

// File: rtl/exec_unit_mul.sv
// Iterative shift-add multiplier, low WIDTH bits of a*b.
// Latency: CYCLES cycles after the start pulse; done is high during the last iteration.
// Backpressure: none; a new start restarts the unit, the product is valid only with done.
module shift_add_mul #(
  parameter int WIDTH  = 16,
  parameter int CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    cnt;
  logic             running;

  // Accumulate the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = acc + mcand;
  end

  // The product is taken from the in-flight sum so it is ready in the final cycle.
  assign done    = running && (cnt == CW'(CYCLES - 1));
  assign product = acc_nxt;

  // Iteration registers: load on start, one shift-add step per cycle while running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= a;
      mplier  <= b;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        running <= 1'b0;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Executes one vr16 instruction: latch operands, ALU or multiply, write back via strobe/ack.
// Latency: start->done 4 cycles (ALU), 4+MUL_CYCLES (MUL), 2 (CMP/illegal), plus ack wait.
// Backpressure: waits indefinitely for write_done; start is ignored (not queued) while busy.
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int WIDTH      = VR16_WIDTH,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [1:0]       src_a,
  input  logic [1:0]       src_b,
  input  logic [1:0]       dest,
  input  logic [WIDTH-1:0] reg_a_out,
  input  logic [WIDTH-1:0] reg_b_out,
  input  logic [WIDTH-1:0] reg_c_out,
  input  logic [WIDTH-1:0] reg_d_out,
  input  logic             write_done,
  output logic             write_enable,
  output logic [1:0]       store_at,
  output logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             done,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             err_flag
);

  state_e           state;
  state_e           state_nxt;
  logic [3:0]       opcode_q;
  logic [1:0]       dest_q;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] alu_nxt;
  logic             carry_nxt;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign store_at = dest_q;

  // Operand selection from the live register file contents.
  always_comb begin
    sel_a = reg_a_out;
    sel_b = reg_a_out;
    case (src_a)
      2'd1:    sel_a = reg_b_out;
      2'd2:    sel_a = reg_c_out;
      2'd3:    sel_a = reg_d_out;
      default: sel_a = reg_a_out;
    endcase
    case (src_b)
      2'd1:    sel_b = reg_b_out;
      2'd2:    sel_b = reg_c_out;
      2'd3:    sel_b = reg_d_out;
      default: sel_b = reg_a_out;
    endcase
  end

  // Single-cycle ALU on the latched operands; carry is the add carry-out or the sub borrow.
  always_comb begin
    alu_nxt   = '0;
    carry_nxt = 1'b0;
    case (opcode_q)
      OP_ADD:         {carry_nxt, alu_nxt} = {1'b0, op_a} + {1'b0, op_b};
      OP_SUB, OP_CMP: begin
        alu_nxt   = op_a - op_b;
        carry_nxt = (op_a < op_b);
      end
      OP_AND:  alu_nxt = op_a & op_b;
      OP_OR:   alu_nxt = op_a | op_b;
      OP_XOR:  alu_nxt = op_a ^ op_b;
      OP_NOT:  alu_nxt = ~op_a;
      OP_SHL:  alu_nxt = op_a << op_b[3:0];
      OP_SHR:  alu_nxt = op_a >> op_b[3:0];
      OP_MOV:  alu_nxt = op_a;
      default: alu_nxt = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and control outputs; strobes are decoded straight from the state.
  always_comb begin
    state_nxt    = state;
    write_enable = 1'b0;
    done         = 1'b0;
    mul_start    = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_IDLE: if (start) state_nxt = S_EXEC;
      S_EXEC: begin
        if (!op_legal(opcode_q) || opcode_q == OP_CMP) begin
          state_nxt = S_DONE;
        end else if (opcode_q == OP_MUL) begin
          state_nxt = S_MUL;
          mul_start = 1'b1;
        end else begin
          state_nxt = S_WRITE;
        end
      end
      S_MUL:      if (mul_done) state_nxt = S_WRITE;
      S_WRITE: begin
        write_enable = 1'b1;
        state_nxt    = S_WAIT_ACK;
      end
      S_WAIT_ACK: if (write_done) state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch at start, register ALU result and flags in EXEC, product at end of MUL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q   <= '0;
      dest_q     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      alu_result <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      err_flag   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            opcode_q <= opcode;
            dest_q   <= dest;
            op_a     <= sel_a;
            op_b     <= sel_b;
          end
        end
        S_EXEC: begin
          err_flag   <= !op_legal(opcode_q);
          carry_flag <= carry_nxt;
          if (opcode_q == OP_CMP) begin
            zero_flag <= (alu_nxt == '0);
          end else if (op_legal(opcode_q) && opcode_q != OP_MUL) begin
            alu_result <= alu_nxt;
            zero_flag  <= (alu_nxt == '0);
          end else begin
            zero_flag <= 1'b0;
          end
        end
        S_MUL: begin
          if (mul_done) begin
            alu_result <= mul_product;
            zero_flag  <= (mul_product == '0);
            carry_flag <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  shift_add_mul #(
    .WIDTH  (WIDTH),
    .CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

endmodule

// File: tb/tb_exec_unit.sv
// Randomized bench for exec_unit with an instruction-level reference model.
// Expected timing comes from per-opcode latency; results from plain arithmetic.
// The bench acts as the register file and answers write strobes after a chosen delay.
module tb_exec_unit;

  localparam int W    = 16;
  localparam int MULC = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   opcode;
  logic [1:0]   src_a, src_b, dest;
  logic [W-1:0] regs [4];
  logic         write_done;
  logic         write_enable;
  logic [1:0]   store_at;
  logic [W-1:0] alu_result;
  logic         busy, done, zero_flag, carry_flag, err_flag;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit checking = 0;

  // model of the instruction in flight
  bit         txn_active = 0;
  bit         t_wr, t_z, t_c, t_e, t_zchk;
  int         t_start = 0, t_L = 0, t_tot = 0;
  logic [1:0] t_dest;
  logic [15:0] t_res;

  // write-ack responder state
  int ack_delay = 0;
  bit ack_pending = 0;
  int ack_wait = 0;

  // observed event bookkeeping
  int done_cyc = 0, we_cyc = 0, we_cnt = 0;

  int c_off;
  bit c_eb, c_ed, c_ew;

  exec_unit #(.WIDTH(W), .MUL_CYCLES(MULC)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .src_a(src_a), .src_b(src_b), .dest(dest),
    .reg_a_out(regs[0]), .reg_b_out(regs[1]), .reg_c_out(regs[2]), .reg_d_out(regs[3]),
    .write_done(write_done), .write_enable(write_enable), .store_at(store_at),
    .alu_result(alu_result), .busy(busy), .done(done),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .err_flag(err_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Instruction semantics as plain arithmetic.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] res, output bit wr, output bit z, output bit c,
                                output bit e, output bit zchk, output int lat);
    int unsigned x;
    res = '0; wr = 1; c = 0; e = 0; zchk = 1; lat = 4;
    case (op)
      4'd0: begin x = 32'(a) + 32'(b); res = x[15:0]; c = (x > 32'hFFFF); end
      4'd1: begin res = a - b; c = (a < b); end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = ~a;
      4'd6: begin x = 32'(a) << b[3:0]; res = x[15:0]; end
      4'd7: res = a >> b[3:0];
      4'd8: begin x = 32'(a) * 32'(b); res = x[15:0]; lat = 4 + MULC; end
      4'd9: res = a;
      4'd10: begin res = a - b; c = (a < b); wr = 0; lat = 2; end
      default: begin wr = 0; lat = 2; e = 1; zchk = 0; end
    endcase
    z = (res == 16'h0);
  endfunction

  // Present an instruction with start=1; called #1 after a rising edge while idle.
  task automatic launch(input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                        input logic [1:0] dst, input int d);
    logic [15:0] r;
    bit wr, z, c, e, zc;
    int lat;
    model(op, regs[sa], regs[sb], r, wr, z, c, e, zc, lat);
    opcode = op; src_a = sa; src_b = sb; dest = dst; start = 1;
    t_res = r; t_wr = wr; t_z = z; t_c = c; t_e = e; t_zchk = zc; t_dest = dst;
    t_L = lat; t_tot = lat + (wr ? d : 0); ack_delay = d;
    t_start = cyc; txn_active = 1;
  endtask

  // Full instruction; optional noise pulses start and scrambles inputs while busy.
  task automatic do_op(input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [1:0] dst, input int d, input bit noise);
    int idx;
    launch(op, sa, sb, dst, d);
    for (int k = 1; k <= t_tot; k++) begin
      @(posedge clk); #1;
      start = 0;
      if (noise) begin
        start  = ($urandom_range(0, 2) == 0);
        opcode = 4'($urandom);
        src_a  = 2'($urandom);
        src_b  = 2'($urandom);
        dest   = 2'($urandom);
        idx    = $urandom_range(0, 3);
        regs[idx] = 16'($urandom);
      end
    end
    @(posedge clk); #1;
    start = 0;
    if (t_wr) regs[dst] = t_res;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_we"}, write_enable, 0);
    chk({tag, "_store_at"}, store_at, 0);
    chk({tag, "_alu_result"}, alu_result, 0);
    chk({tag, "_zero"}, zero_flag, 0);
    chk({tag, "_carry"}, carry_flag, 0);
    chk({tag, "_err"}, err_flag, 0);
  endtask

  // Register file write acknowledge, ack_delay cycles after the strobe.
  initial begin
    write_done = 0;
    forever begin
      @(posedge clk); #1;
      write_done = 0;
      if (reset) ack_pending = 0;
      else if (ack_pending) begin
        if (ack_wait == 0) begin write_done = 1; ack_pending = 0; end
        else ack_wait--;
      end else if (write_enable) begin
        ack_pending = 1;
        ack_wait = ack_delay;
      end
    end
  end

  // Observed strobe timing for the literal latency checks.
  always @(negedge clk) begin
    if (done) done_cyc = cyc;
    if (write_enable) begin we_cyc = cyc; we_cnt++; end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (checking && !reset) begin
      c_off = cyc - t_start;
      c_eb = txn_active && c_off >= 1 && c_off <= t_tot;
      c_ed = txn_active && c_off == t_tot;
      c_ew = txn_active && t_wr && c_off == t_L - 2;
      chk("busy", busy, c_eb);
      chk("done", done, c_ed);
      chk("write_enable", write_enable, c_ew);
      if (txn_active && t_wr && c_off >= t_L - 2 && c_off <= t_tot) begin
        chk("alu_result", alu_result, t_res);
        chk("store_at", store_at, t_dest);
      end
      if (c_ed) begin
        chk("carry_flag", carry_flag, t_c);
        chk("err_flag", err_flag, t_e);
        if (t_zchk) chk("zero_flag", zero_flag, t_z);
      end
    end
  end

  initial begin
    int we_before;
    logic [3:0] op;
    reset = 1; start = 0; opcode = 0; src_a = 0; src_b = 0; dest = 0;
    for (int i = 0; i < 4; i++) regs[i] = '0;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 0;
    checking = 1;
    @(posedge clk); #1;

    // ADD A+B -> C
    regs[0] = 16'h0003; regs[1] = 16'h0005;
    we_before = we_cnt;
    do_op(4'd0, 2'd0, 2'd1, 2'd2, 0, 0);
    chk("add_result", alu_result, 16'h0008);
    chk("add_store_at", store_at, 2'b10);
    chk("add_zero", zero_flag, 0);
    chk("add_carry", carry_flag, 0);
    chk("add_done_latency", done_cyc - t_start, 4);
    chk("add_we_pulses", we_cnt - we_before, 1);

    // ADD overflow and SUB borrow
    regs[0] = 16'hFFFF; regs[1] = 16'h0001;
    do_op(4'd0, 2'd0, 2'd1, 2'd3, 0, 0);
    chk("addovf_result", alu_result, 16'h0000);
    chk("addovf_zero", zero_flag, 1);
    chk("addovf_carry", carry_flag, 1);
    do_op(4'd1, 2'd1, 2'd0, 2'd2, 0, 0);
    chk("sub_result", alu_result, 16'h0002);
    chk("sub_carry", carry_flag, 1);

    // MUL low half
    regs[0] = 16'h0100; regs[1] = 16'h0101;
    do_op(4'd8, 2'd0, 2'd1, 2'd0, 0, 0);
    chk("mul_result", alu_result, 16'h0100);
    chk("mul_we_latency", we_cyc - t_start, 18);
    chk("mul_done_latency", done_cyc - t_start, 20);

    // CMP and illegal opcode: no write
    regs[0] = 16'h1234; regs[1] = 16'h1234;
    we_before = we_cnt;
    do_op(4'd10, 2'd0, 2'd1, 2'd2, 0, 0);
    chk("cmp_zero", zero_flag, 1);
    chk("cmp_done_latency", done_cyc - t_start, 2);
    do_op(4'hF, 2'd0, 2'd1, 2'd2, 0, 0);
    chk("illegal_err", err_flag, 1);
    chk("illegal_done_latency", done_cyc - t_start, 2);
    chk("cmp_illegal_no_we", we_cnt - we_before, 0);

    // Stalled ack with start pulses while busy
    regs[0] = 16'h0007; regs[1] = 16'h0009;
    do_op(4'd0, 2'd0, 2'd1, 2'd1, 10, 1);
    chk("stall_result", alu_result, 16'h0010);
    chk("stall_done_latency", done_cyc - t_start, 14);

    // Reset in the 7th MUL cycle abandons the instruction
    regs[0] = 16'h00FF; regs[1] = 16'h0003;
    launch(4'd8, 2'd0, 2'd1, 2'd3, 0);
    for (int k = 0; k < 8; k++) begin @(posedge clk); #1; start = 0; end
    reset = 1;
    txn_active = 0;
    #1;
    chk_all_zero("midmul_reset");
    @(posedge clk); #1;
    reset = 0;
    we_before = we_cnt;
    for (int k = 0; k < 25; k++) begin @(posedge clk); #1; end
    chk("no_we_after_reset", we_cnt - we_before, 0);
    do_op(4'd8, 2'd0, 2'd1, 2'd3, 0, 0);
    chk("mul_after_reset", alu_result, 16'h02FD);

    // Randomized back-to-back instructions
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(11, 15));
      else op = 4'($urandom_range(0, 10));
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 4; i++) regs[i] = 16'($urandom);
      end
      do_op(op, 2'($urandom), 2'($urandom), 2'($urandom),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    txn_active = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
